// File: rtl/xor_fault_ctrl_pkg.sv
// Shared definitions for the XOR fault-injection sequencer.
// Holds the FSM state encoding, default timing constants and a small
// helper used to size the phase timer.
package xor_fault_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOCATE = 3'd1,
        ST_APPLY  = 3'd2,
        ST_PULSE  = 3'd3,
        ST_WINDOW = 3'd4,
        ST_REPORT = 3'd5
    } state_t;

    localparam int DEF_SETTLE_CYC = 16;
    localparam int DEF_PULSE_CYC  = 4;
    localparam int DEF_WINDOW_CYC = 32;
    localparam int DEF_CNT_W      = 16;

    function automatic int max3(input int x, input int y, input int z);
        int m;
        m = (x > y) ? x : y;
        return (m > z) ? m : z;
    endfunction

endpackage

// File: rtl/xor_fault_ctrl_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit.
// Ports: sysclk - clock, rst - async active-high reset,
//        d - asynchronous input, q - synchronised output (2 cycles latency).
module sync_2ff (
    input  logic sysclk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule

// File: rtl/xor_fault_ctrl.sv
// Test sequencer for the laser-attacked XOR target.
// Applies a latched 6-bit pattern, fires a timed laser pulse, counts cycles
// where the synchronised target output differs from the pattern parity, and
// reports each trial over a valid/ready handshake. Locate mode drives osc_en.
//
// state  | meaning
// IDLE   | waiting for start or locate_req
// LOCATE | osc_en high, gate toggled for emission localisation
// APPLY  | pattern applied, target settling
// PULSE  | laser_trig high, comparison active
// WINDOW | post-pulse observation, comparison active
// REPORT | result valid, waiting for res_ready
//
// Ports: sysclk/rst clock and async reset; start/pattern trial request;
// locate_req locate mode level; q_in target output; a target inputs;
// osc_en clock-injection enable; laser_trig laser strobe; busy not-idle;
// res_* result handshake; clear_cnt/total_faults running fault tally.
module xor_fault_ctrl
    import xor_fault_ctrl_pkg::*;
#(
    parameter int SETTLE_CYC = DEF_SETTLE_CYC,
    parameter int PULSE_CYC  = DEF_PULSE_CYC,
    parameter int WINDOW_CYC = DEF_WINDOW_CYC,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic             sysclk,
    input  logic             rst,
    input  logic             start,
    input  logic [5:0]       pattern,
    input  logic             locate_req,
    input  logic             q_in,
    output logic [5:0]       a,
    output logic             osc_en,
    output logic             laser_trig,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_fault,
    output logic [CNT_W-1:0] res_err_cnt,
    output logic [5:0]       res_pattern,
    input  logic             clear_cnt,
    output logic [CNT_W-1:0] total_faults
);

    localparam int TMR_MAX = max3(SETTLE_CYC, PULSE_CYC, WINDOW_CYC);
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [TMR_W-1:0]   r_tmr;
    logic [TMR_W-1:0]   w_tmr_nxt;
    logic               w_tc;
    logic               w_accept;
    logic               w_handshake;
    logic               w_q_s;
    logic               w_cmp_en;
    logic [CNT_W-1:0]   r_err;
    logic [CNT_W-1:0]   w_err_nxt;
    logic [5:0]         r_a;
    logic               r_exp;
    logic               r_osc;
    logic               r_laser;
    logic               r_busy;
    logic               r_valid;
    logic               r_res_fault;
    logic [CNT_W-1:0]   r_res_err;
    logic [5:0]         r_res_pat;
    logic [CNT_W-1:0]   r_total;

    sync_2ff u_sync (
        .sysclk (sysclk),
        .rst    (rst),
        .d      (q_in),
        .q      (w_q_s)
    );

    assign w_tc     = (r_tmr == '0);
    assign w_cmp_en = (r_state == ST_PULSE) || (r_state == ST_WINDOW);

    always_comb begin
        w_state_nxt = r_state;
        w_tmr_nxt   = r_tmr;
        w_accept    = 1'b0;
        w_handshake = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // locate_req takes priority over a coincident start
                if (locate_req) begin
                    w_state_nxt = ST_LOCATE;
                end else if (start) begin
                    w_state_nxt = ST_APPLY;
                    w_tmr_nxt   = TMR_W'(SETTLE_CYC - 1);
                    w_accept    = 1'b1;
                end
            end
            ST_LOCATE: begin
                if (!locate_req) w_state_nxt = ST_IDLE;
            end
            ST_APPLY: begin
                if (w_tc) begin
                    w_state_nxt = ST_PULSE;
                    w_tmr_nxt   = TMR_W'(PULSE_CYC - 1);
                end else begin
                    w_tmr_nxt = r_tmr - TMR_W'(1);
                end
            end
            ST_PULSE: begin
                if (w_tc) begin
                    w_state_nxt = ST_WINDOW;
                    w_tmr_nxt   = TMR_W'(WINDOW_CYC - 1);
                end else begin
                    w_tmr_nxt = r_tmr - TMR_W'(1);
                end
            end
            ST_WINDOW: begin
                if (w_tc) w_state_nxt = ST_REPORT;
                else      w_tmr_nxt   = r_tmr - TMR_W'(1);
            end
            ST_REPORT: begin
                if (res_ready) begin
                    w_state_nxt = ST_IDLE;
                    w_handshake = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_err_nxt = r_err;
        if (w_accept) begin
            w_err_nxt = '0;
        end else if (w_cmp_en && (w_q_s != r_exp) && (r_err != '1)) begin
            w_err_nxt = r_err + CNT_W'(1);
        end
    end

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_tmr   <= '0;
            r_err   <= '0;
            r_a     <= '0;
            r_exp   <= 1'b0;
            r_osc   <= 1'b0;
            r_laser <= 1'b0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_tmr   <= w_tmr_nxt;
            r_err   <= w_err_nxt;
            if (w_accept) begin
                r_a   <= pattern;
                r_exp <= ^pattern;
            end
            // strobes are registered from the next state so they never glitch
            r_osc   <= (w_state_nxt == ST_LOCATE);
            r_laser <= (w_state_nxt == ST_PULSE);
            r_busy  <= (w_state_nxt != ST_IDLE);
            r_valid <= (w_state_nxt == ST_REPORT);
        end
    end

    // Results are captured on REPORT entry, including the last window cycle's
    // comparison, and held until the next trial reaches REPORT.
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            r_res_fault <= 1'b0;
            r_res_err   <= '0;
            r_res_pat   <= '0;
        end else if ((r_state == ST_WINDOW) && (w_state_nxt == ST_REPORT)) begin
            r_res_fault <= (w_err_nxt != '0);
            r_res_err   <= w_err_nxt;
            r_res_pat   <= r_a;
        end
    end

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            r_total <= '0;
        end else if (clear_cnt) begin
            r_total <= '0;
        end else if (w_handshake && r_res_fault && (r_total != '1)) begin
            r_total <= r_total + CNT_W'(1);
        end
    end

    assign a            = r_a;
    assign osc_en       = r_osc;
    assign laser_trig   = r_laser;
    assign busy         = r_busy;
    assign res_valid    = r_valid;
    assign res_fault    = r_res_fault;
    assign res_err_cnt  = r_res_err;
    assign res_pattern  = r_res_pat;
    assign total_faults = r_total;

endmodule

// File: tb/tb_xor_fault_ctrl.sv
// Directed bench for xor_fault_ctrl. Two instances share stimulus: one with
// default parameters and one with CNT_W=4 for counter saturation.
// Each target model returns the parity of its inputs, optionally inverted.
module tb_xor_fault_ctrl;

    logic        sysclk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  pattern = '0;
    logic        locate_req = 1'b0;
    logic        res_ready = 1'b0;
    logic        clear_cnt = 1'b0;
    logic        inv = 1'b0;

    logic [5:0]  a, res_pattern;
    logic        osc_en, laser_trig, busy, res_valid, res_fault, q_in;
    logic [15:0] res_err_cnt, total_faults;

    logic [5:0]  a2, res_pattern2;
    logic        osc_en2, laser_trig2, busy2, res_valid2, res_fault2, q_in2;
    logic [3:0]  res_err_cnt2, total_faults2;

    int n_tests = 0;
    int n_fail = 0;
    int exp_tot = 0;
    int exp_tot4 = 0;

    assign q_in  = (^a) ^ inv;
    assign q_in2 = (^a2) ^ inv;

    always #5 sysclk = ~sysclk;

    xor_fault_ctrl dut (
        .sysclk(sysclk), .rst(rst), .start(start), .pattern(pattern),
        .locate_req(locate_req), .q_in(q_in), .a(a), .osc_en(osc_en),
        .laser_trig(laser_trig), .busy(busy), .res_valid(res_valid),
        .res_ready(res_ready), .res_fault(res_fault), .res_err_cnt(res_err_cnt),
        .res_pattern(res_pattern), .clear_cnt(clear_cnt), .total_faults(total_faults)
    );

    xor_fault_ctrl #(.CNT_W(4)) dut4 (
        .sysclk(sysclk), .rst(rst), .start(start), .pattern(pattern),
        .locate_req(locate_req), .q_in(q_in2), .a(a2), .osc_en(osc_en2),
        .laser_trig(laser_trig2), .busy(busy2), .res_valid(res_valid2),
        .res_ready(res_ready), .res_fault(res_fault2), .res_err_cnt(res_err_cnt2),
        .res_pattern(res_pattern2), .clear_cnt(clear_cnt), .total_faults(total_faults2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one trial from IDLE. q_in is inverted during cycles inv_lo..inv_hi
    // (cycle 0 = start cycle). hold = cycles of res_ready=0 in REPORT.
    task automatic run_trial(input logic [5:0] pat, input int inv_lo, input int inv_hi,
                             input int exp_err, input int hold, input logic clr);
        int exp_err4;
        int prev_tot;
        int prev_tot4;
        exp_err4 = (exp_err > 15) ? 15 : exp_err;
        pattern = pat;
        start = 1'b1;
        @(negedge sysclk);
        start = 1'b0;
        for (int cyc = 1; cyc <= 53; cyc++) begin
            inv = (cyc >= inv_lo) && (cyc <= inv_hi);
            if (cyc == 1) begin
                check("a_applied", a, pat);
                check("busy_apply", busy, 1);
                check("osc_off_trial", osc_en, 0);
            end
            if (cyc == 16) check("laser_pre", laser_trig, 0);
            if (cyc == 17) check("laser_first", laser_trig, 1);
            if (cyc == 20) check("laser_last", laser_trig, 1);
            if (cyc == 21) check("laser_post", laser_trig, 0);
            if (cyc == 52) check("valid_early", res_valid, 0);
            if (cyc == 53) begin
                check("valid_53", res_valid, 1);
                check("res_fault", res_fault, (exp_err != 0) ? 1 : 0);
                check("res_err_cnt", res_err_cnt, exp_err);
                check("res_pattern", res_pattern, pat);
                check("res_err_cnt4", res_err_cnt2, exp_err4);
                check("busy_report", busy, 1);
            end
            if (cyc < 53) @(negedge sysclk);
        end
        inv = 1'b0;
        prev_tot  = exp_tot;
        prev_tot4 = exp_tot4;
        for (int h = 0; h < hold; h++) begin
            start      = h[0];
            locate_req = ~h[0];
            @(negedge sysclk);
            check("hold_valid", res_valid, 1);
            check("hold_err", res_err_cnt, exp_err);
            check("hold_tot", total_faults, prev_tot);
            check("hold_a", a, pat);
        end
        start = 1'b0;
        locate_req = 1'b0;
        res_ready = 1'b1;
        clear_cnt = clr;
        @(negedge sysclk);
        res_ready = 1'b0;
        clear_cnt = 1'b0;
        if (clr) begin
            exp_tot  = 0;
            exp_tot4 = 0;
        end else if (exp_err != 0) begin
            exp_tot  = exp_tot + 1;
            exp_tot4 = (exp_tot4 == 15) ? 15 : exp_tot4 + 1;
        end
        check("valid_drop", res_valid, 0);
        check("busy_idle", busy, 0);
        check("total", total_faults, exp_tot);
        check("total4", total_faults2, exp_tot4);
        check("res_retained", res_pattern, pat);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge sysclk);
        @(negedge sysclk);
        rst = 1'b0;
        exp_tot  = 0;
        exp_tot4 = 0;
        @(negedge sysclk);
    endtask

    initial begin
        // reset values
        @(negedge sysclk);
        @(negedge sysclk);
        check("rst_a", a, 0);
        check("rst_osc", osc_en, 0);
        check("rst_laser", laser_trig, 0);
        check("rst_busy", busy, 0);
        check("rst_valid", res_valid, 0);
        check("rst_err", res_err_cnt, 0);
        check("rst_tot", total_faults, 0);
        rst = 1'b0;
        @(negedge sysclk);

        // 1: clean trial
        run_trial(6'b101101, 100, 0, 0, 0, 1'b0);
        // 2: three inverted cycles inside the window
        run_trial(6'b101101, 22, 24, 3, 0, 1'b0);
        // 3: back-pressure with start/locate pulses in REPORT
        run_trial(6'b101101, 22, 24, 3, 10, 1'b0);
        check("no_new_trial", busy, 0);

        // 4: locate mode
        run_trial(6'b000011, 100, 0, 0, 0, 1'b0);
        locate_req = 1'b1;
        start = 1'b1;
        pattern = 6'b111111;
        @(negedge sysclk);
        start = 1'b0;
        check("loc_osc", osc_en, 1);
        check("loc_busy", busy, 1);
        check("loc_a", a, 6'b000011);
        start = 1'b1;
        @(negedge sysclk);
        start = 1'b0;
        @(negedge sysclk);
        check("loc_no_laser", laser_trig, 0);
        check("loc_a_held", a, 6'b000011);
        locate_req = 1'b0;
        @(negedge sysclk);
        check("loc_exit_osc", osc_en, 0);
        check("loc_exit_busy", busy, 0);
        @(negedge sysclk);
        check("loc_stay_idle", busy, 0);

        // 5: reset during PULSE
        pattern = 6'b110001;
        start = 1'b1;
        @(negedge sysclk);
        start = 1'b0;
        for (int c = 1; c < 18; c++) @(negedge sysclk);
        check("pre_rst_laser", laser_trig, 1);
        #1 rst = 1'b1;
        #1;
        check("rst_async_laser", laser_trig, 0);
        check("rst_async_a", a, 0);
        check("rst_async_busy", busy, 0);
        check("rst_async_tot", total_faults, 0);
        check("rst_async_pat", res_pattern, 0);
        @(negedge sysclk);
        rst = 1'b0;
        exp_tot = 0;
        exp_tot4 = 0;
        @(negedge sysclk);
        run_trial(6'b110001, 100, 0, 0, 0, 1'b0);

        // 6: saturation of the 4-bit tally, then clear vs increment
        do_reset();
        for (int t = 0; t < 17; t++) run_trial(6'b010110, 22, 24, 3, 0, 1'b0);
        check("sat_tot4", total_faults2, 15);
        check("unsat_tot16", total_faults, 17);
        // q_s wrong for cycles 19..54; compared cycles 17..52 -> 34 mismatches
        run_trial(6'b010110, 17, 52, 34, 0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
